keycode_repeater: RTL
=====================

KEYCODE_REPEATER -- requirements
Module: keycode_repeater

Interface
REQ-001 Parameter PULSE_FRAMES, default 2, frames the output code is held nonzero per press or repeat.
REQ-002 Parameter DELAY_FRAMES, default 30, frames of zero output before the first auto-repeat.
REQ-003 Parameter REPEAT_FRAMES, default 6, frames of zero output between subsequent auto-repeats.
REQ-004 Clk  input  1  system clock (50 MHz); all state is clocked on its rising edge.
REQ-005 Reset  input  1  reset; Reset is asynchronous, active-high.
REQ-006 frame_clk  input  1  VGA frame strobe (~60 Hz), asynchronous to Clk.
REQ-007 raw_keycode  input  8  current keyboard code from the USB host; 0 means no key.
REQ-008 keycode  output  8  shaped code for the cursor/letter logic; 0 between pulses.
REQ-009 key_event  output  1  one-Clk pulse on each press or repeat that drives keycode nonzero.
REQ-010 key_held  output  1  high while a key is being tracked (states ON and OFF).

Function
REQ-011 frame_clk shall pass through a 2-flop synchronizer; a rising edge of the synchronized signal produces a one-Clk frame_tick.
REQ-012 raw_keycode shall be registered once in the Clk domain before use (raw_q).
REQ-013 The FSM states shall be IDLE, ON, OFF and GAP; keycode is 0 in every state except ON.
REQ-014 IDLE: when raw_q != 0, latch code <= raw_q, pulse key_event, set first <= 1, clear frame count, go to ON on the next Clk.
REQ-015 ON: keycode = code; frame count increments on each frame_tick; when the count reaches PULSE_FRAMES, go to OFF and clear the count.
REQ-016 ON: if raw_q != code (including 0), go to GAP immediately; this takes priority over the frame_tick count.
REQ-017 OFF: frame count increments on each frame_tick; threshold = DELAY_FRAMES if first = 1, else REPEAT_FRAMES.
REQ-018 OFF: when the count reaches the threshold and raw_q == code, go to ON, pulse key_event, clear first, and clear the count.
REQ-019 OFF: if raw_q != code, go to GAP; this takes priority over reaching the threshold in the same cycle.
REQ-020 GAP: keycode = 0; on the first frame_tick, go to IDLE, so every nonzero keycode is preceded by at least one full-frame boundary of 0.
REQ-021 The keycode output shall never change directly from one nonzero value to a different nonzero value.
REQ-022 The frame counter shall be 8 bits wide, saturate at 255, and never wrap.
REQ-023 Parameters of 0 shall be treated as 1.
REQ-024 Outputs shall be registered; keycode and key_event update on the same Clk edge as the state transition.
REQ-025 key_event shall be high for exactly one Clk per entry into ON.

Reset
REQ-026 Reset asserted shall force state IDLE, keycode = 0, key_event = 0, key_held = 0, code = 0, count = 0, first = 1, and synchronizer flops = 0, regardless of Clk.
REQ-027 Reset asserted mid-pulse (ON) shall drop keycode to 0 asynchronously.
REQ-028 After deassertion with raw_q != 0, a new press shall register: IDLE -> ON within 2 Clk of the first Clk edge.

Verification
REQ-029 Tap: raw = 0x4F for 1 frame, then 0 -> keycode = 0x4F for 1 frame (truncated by release), one key_event, then GAP -> IDLE, keycode = 0.
REQ-030 Hold: raw = 0x51 for 60 frames -> keycode = 0x51 at frames 0-1, next at frame 32, then every 8 frames (40, 48, 56); key_event count = 5.
REQ-031 Switch: raw changes 0x50 -> 0x52 in ON with no 0 in between -> keycode goes 0 for at least 1 frame_tick, then 0x52 with a new key_event; no direct 0x50 -> 0x52 transition.
REQ-032 Simultaneous: release lands in the same Clk as the OFF threshold frame_tick -> GAP entered, no key_event, keycode stays 0.
REQ-033 Reset mid-ON with keycode = 0x4F -> keycode = 0 asynchronously, key_held = 0; hold raw = 0x4F through deassertion -> fresh press with first-repeat delay of 30 frames.
REQ-034 Async frame_clk: frame_clk edges jittered relative to Clk -> exactly one frame_tick per frame_clk rising edge, with no missed or double counts over 100 frames.

Source files
------------

// File: rtl/keycode_repeater.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : keycode_repeater
// Description : Turns a raw USB keyboard code into frame-timed pulses with an
//               initial pulse, a long first-repeat delay, then periodic
//               auto-repeat. Every nonzero pulse is separated from a different
//               code by at least one frame boundary of zero output.
// Revision    : 1.0 - initial release
// ============================================================================
module keycode_repeater #(
  parameter int PULSE_FRAMES  = 2,
  parameter int DELAY_FRAMES  = 30,
  parameter int REPEAT_FRAMES = 6
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] raw_keycode,
  output logic [7:0] keycode,
  output logic       key_event,
  output logic       key_held
);

  // Zero-length phases are stretched to one frame; the 8-bit counter
  // saturates at 255, so larger settings are clipped to what it can reach.
  function automatic logic [7:0] clamp_frames(input int val);
    if (val <= 0) begin
      return 8'd1;
    end else if (val >= 255) begin
      return 8'd255;
    end else begin
      return val[7:0];
    end
  endfunction

  localparam logic [7:0] c_pulse  = clamp_frames(PULSE_FRAMES);
  localparam logic [7:0] c_delay  = clamp_frames(DELAY_FRAMES);
  localparam logic [7:0] c_repeat = clamp_frames(REPEAT_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  logic       frame_meta_q;
  logic       frame_sync_q;
  logic       frame_prev_q;
  logic       frame_tick;
  logic [7:0] raw_q;

  state_t     state_q, state_d;
  logic [7:0] code_q, code_d;
  logic [7:0] cnt_q, cnt_d;
  logic       first_q, first_d;
  logic       event_d;
  logic [7:0] keycode_d;
  logic       held_d;

  logic [7:0] keycode_q;
  logic       key_event_q;
  logic       key_held_q;

  logic [7:0] cnt_inc;
  logic [7:0] threshold;

  // Bring frame_clk into the Clk domain and register the raw code once.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_meta_q <= 1'b0;
      frame_sync_q <= 1'b0;
      frame_prev_q <= 1'b0;
      raw_q        <= 8'd0;
    end else begin
      frame_meta_q <= frame_clk;
      frame_sync_q <= frame_meta_q;
      frame_prev_q <= frame_sync_q;
      raw_q        <= raw_keycode;
    end
  end

  assign frame_tick = frame_sync_q & ~frame_prev_q;
  assign cnt_inc    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign threshold  = first_q ? c_delay : c_repeat;

  // Next-state and next-output logic; a code mismatch always wins over a
  // frame count reaching its limit in the same cycle.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    event_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (raw_q != 8'd0) begin
          code_d  = raw_q;
          first_d = 1'b1;
          cnt_d   = 8'd0;
          event_d = 1'b1;
          state_d = S_ON;
        end
      end
      S_ON: begin
        if (raw_q != code_q) begin
          state_d = S_GAP;
          cnt_d   = 8'd0;
        end else if (frame_tick) begin
          if (cnt_inc >= c_pulse) begin
            state_d = S_OFF;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_OFF: begin
        if (raw_q != code_q) begin
          state_d = S_GAP;
          cnt_d   = 8'd0;
        end else if (frame_tick) begin
          if (cnt_inc >= threshold) begin
            state_d = S_ON;
            cnt_d   = 8'd0;
            first_d = 1'b0;
            event_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_GAP: begin
        if (frame_tick) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    keycode_d = (state_d == S_ON) ? code_d : 8'd0;
    held_d    = (state_d == S_ON) || (state_d == S_OFF);
  end

  // State and registered outputs advance together so keycode follows the FSM.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      code_q      <= 8'd0;
      cnt_q       <= 8'd0;
      first_q     <= 1'b1;
      keycode_q   <= 8'd0;
      key_event_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      keycode_q   <= keycode_d;
      key_event_q <= event_d;
      key_held_q  <= held_d;
    end
  end

  assign keycode   = keycode_q;
  assign key_event = key_event_q;
  assign key_held  = key_held_q;

endmodule
`default_nettype wire
